// File: rtl/seg7_scan_driver.sv
// Serial scan driver for up to 8 multiplexed 7-segment digits behind a pair of 74HC595s.
// Each digit frame shifts a select byte, then a segment byte, then pulses the storage latch.
module seg7_scan_driver #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned CLK_DIV     = 6250,
    parameter int unsigned SEG_INV     = 0,
    parameter int unsigned LZ_SUPPRESS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  hex_mode,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  rclk,
    output logic                  srclr_n,
    output logic                  scan_done
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0]     div_q;
    logic [5:0]          step_q;
    logic [2:0]          digit_q;
    logic                sclk_q, sdata_q, rclk_q, srclr_n_q, scan_done_q;

    logic [4*DIGITS-1:0] disp_value_q, pend_value_q;
    logic [DIGITS-1:0]   disp_dp_q, pend_dp_q;
    logic [DIGITS-1:0]   disp_blank_q, pend_blank_q;
    logic                disp_hex_q, pend_hex_q;
    logic                pend_full_q;

    logic                tick, last_step, last_digit, load_accept;
    logic [31:0]         val_pad;
    logic [7:0]          dp_pad, blk_pad, lz_mask, sel_byte, seg_byte;
    logic [3:0]          nib, slot;
    logic [6:0]          glyph;
    logic                lz_run, seg_blank, bit_val;

    assign tick        = (div_q == CntW'(CLK_DIV - 1));
    assign last_step   = (step_q == 6'd35);
    assign last_digit  = (digit_q == 3'(DIGITS - 1));
    assign load_ready  = !pend_full_q;
    assign load_accept = load_valid && load_ready;

    // Decode the digit currently being scanned from the display register only.
    always_comb begin
        val_pad = 32'(disp_value_q);
        dp_pad  = 8'(disp_dp_q);
        blk_pad = 8'(disp_blank_q);
        nib     = val_pad[{digit_q, 2'b00} +: 4];

        lz_run  = 1'b1;
        lz_mask = '0;
        for (int i = 7; i >= 0; i--) begin
            lz_run     = lz_run && (val_pad[4*i +: 4] == 4'h0) && !dp_pad[i];
            lz_mask[i] = lz_run;
        end

        unique case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase

        seg_blank = blk_pad[digit_q]
                  || (!disp_hex_q && (nib > 4'd9))
                  || ((LZ_SUPPRESS != 0) && (digit_q != 3'd0) && lz_mask[digit_q]);
        seg_byte  = seg_blank ? 8'h00 : {dp_pad[digit_q], glyph};
        if (SEG_INV != 0) begin
            seg_byte = ~seg_byte;
        end

        sel_byte          = 8'hFF;
        sel_byte[digit_q] = 1'b0;

        // Slots 0-7 carry the select byte, 8-15 the segment byte, both MSB first.
        slot    = step_q[4:1];
        bit_val = slot[3] ? seg_byte[~slot[2:0]] : sel_byte[~slot[2:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            step_q       <= '0;
            digit_q      <= '0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b1;
            rclk_q       <= 1'b0;
            srclr_n_q    <= 1'b0;
            scan_done_q  <= 1'b0;
            disp_value_q <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '1;
            disp_hex_q   <= 1'b0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_hex_q   <= 1'b0;
            pend_full_q  <= 1'b0;
        end else begin
            srclr_n_q   <= 1'b1;
            scan_done_q <= 1'b0;

            if (load_accept) begin
                pend_value_q <= value;
                pend_dp_q    <= dp;
                pend_blank_q <= blank;
                pend_hex_q   <= hex_mode;
                pend_full_q  <= 1'b1;
            end

            if (tick) begin
                div_q <= '0;

                // Swap buffers only at a scan boundary so one scan never mixes data.
                if ((step_q == 6'd0) && (digit_q == 3'd0) && pend_full_q) begin
                    disp_value_q <= pend_value_q;
                    disp_dp_q    <= pend_dp_q;
                    disp_blank_q <= pend_blank_q;
                    disp_hex_q   <= pend_hex_q;
                    pend_full_q  <= 1'b0;
                end

                if (step_q < 6'd32) begin
                    sclk_q <= step_q[0];
                    rclk_q <= 1'b0;
                    if (!step_q[0]) begin
                        sdata_q <= bit_val;
                    end
                end else begin
                    sclk_q <= 1'b0;
                    rclk_q <= (step_q < 6'd34);
                end

                if (last_step) begin
                    step_q      <= '0;
                    digit_q     <= last_digit ? 3'd0 : digit_q + 3'd1;
                    scan_done_q <= last_digit;
                end else begin
                    step_q <= step_q + 6'd1;
                end
            end else begin
                div_q <= div_q + CntW'(1);
            end
        end
    end

    assign sclk      = sclk_q;
    assign sdata     = sdata_q;
    assign rclk      = rclk_q;
    assign srclr_n   = srclr_n_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: three driver instances (plain, leading-zero blanking, inverted segments)
// share stimulus; a monitor rebuilds each latched 16-bit frame and checks it against the queue.
module tb_seg7_scan_driver;

    typedef struct packed {
        logic [1:0]  inst;
        logic [2:0]  digit;
        logic [15:0] frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic [7:0]  dp, blank;
    logic        hex_mode, load_valid;
    logic [2:0]  load_ready_w, sclk_w, sdata_w, rclk_w, srclr_n_w, scan_done_w;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_scan_driver #(.DIGITS(8), .CLK_DIV(2), .SEG_INV(0), .LZ_SUPPRESS(0)) u_plain (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .hex_mode(hex_mode),
        .load_valid(load_valid), .load_ready(load_ready_w[0]), .sclk(sclk_w[0]),
        .sdata(sdata_w[0]), .rclk(rclk_w[0]), .srclr_n(srclr_n_w[0]),
        .scan_done(scan_done_w[0])
    );

    seg7_scan_driver #(.DIGITS(8), .CLK_DIV(2), .SEG_INV(0), .LZ_SUPPRESS(1)) u_lz (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .hex_mode(hex_mode),
        .load_valid(load_valid), .load_ready(load_ready_w[1]), .sclk(sclk_w[1]),
        .sdata(sdata_w[1]), .rclk(rclk_w[1]), .srclr_n(srclr_n_w[1]),
        .scan_done(scan_done_w[1])
    );

    seg7_scan_driver #(.DIGITS(8), .CLK_DIV(2), .SEG_INV(1), .LZ_SUPPRESS(0)) u_inv (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .hex_mode(hex_mode),
        .load_valid(load_valid), .load_ready(load_ready_w[2]), .sclk(sclk_w[2]),
        .sdata(sdata_w[2]), .rclk(rclk_w[2]), .srclr_n(srclr_n_w[2]),
        .scan_done(scan_done_w[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected bytes are {digit7 .. digit0}; the inverted instance shows the plain bytes inverted.
    task automatic push_scan(input logic [63:0] plain, input logic [63:0] lz, input int ndig);
        logic [7:0] sel;
        for (int d = 0; d < ndig; d++) begin
            sel    = 8'hFF;
            sel[d] = 1'b0;
            exp_q.push_back('{inst: 2'd0, digit: 3'(d), frame: {sel, plain[8*d +: 8]}});
            exp_q.push_back('{inst: 2'd1, digit: 3'(d), frame: {sel, lz[8*d +: 8]}});
            exp_q.push_back('{inst: 2'd2, digit: 3'(d), frame: {sel, ~plain[8*d +: 8]}});
        end
    endtask

    task automatic check_reset_outs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s outs inst%0d", tag, i),
                  32'({sclk_w[i], rclk_w[i], sdata_w[i], srclr_n_w[i], scan_done_w[i],
                       load_ready_w[i]}),
                  32'(6'b001001));
        end
    endtask

    task automatic wait_scan_done();
        int n = 0;
        while (!scan_done_w[0] && n < 1500) begin
            @(negedge clk);
            n++;
        end
        if (!scan_done_w[0]) begin
            n_vec++;
            n_err++;
            $display("FAIL scan_done timeout: got 0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic next_scan(input logic [63:0] plain, input logic [63:0] lz);
        wait_scan_done();
        check("scan_done all instances", 32'(scan_done_w), 32'(3'b111));
        push_scan(plain, lz, 8);
        @(negedge clk);
        check("scan_done single cycle", 32'(scan_done_w), 32'(3'b000));
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] p, input logic [7:0] b,
                           input logic h);
        int n = 0;
        repeat (20) @(negedge clk);
        value      = v;
        dp         = p;
        blank      = b;
        hex_mode   = h;
        load_valid = 1'b1;
        while (!load_ready_w[0] && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("load accepted", 32'(load_ready_w), 32'(3'b111));
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Input churn without a load must never reach the display.
    task automatic scramble();
        repeat (5) begin
            @(negedge clk);
            value    = $urandom;
            dp       = 8'($urandom);
            blank    = 8'($urandom);
            hex_mode = 1'($urandom);
        end
    endtask

    initial begin : monitor
        logic [15:0] sh [3];
        logic        ps [3];
        logic        pr [3];
        int          rh [3];
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            sh[i] = '0;
            ps[i] = 1'b0;
            pr[i] = 1'b0;
            rh[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (sclk_w[i] && !ps[i]) sh[i] = {sh[i][14:0], sdata_w[i]};
                if (rclk_w[i] && !pr[i]) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected frame inst%0d: got %h, required none", i, sh[i]);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("frame inst%0d digit%0d", e.inst, e.digit),
                              32'({2'(i), sh[i]}), 32'({e.inst, e.frame}));
                    end
                end
                if (rclk_w[i]) rh[i]++;
                if (!rclk_w[i] && pr[i]) begin
                    check($sformatf("rclk width inst%0d", i), 32'(rh[i]), 32'd4);
                    rh[i] = 0;
                end
                ps[i] = sclk_w[i];
                pr[i] = rclk_w[i];
            end
        end
    end

    initial begin : stimulus
        int c0;
        rst        = 1'b1;
        value      = '0;
        dp         = '0;
        blank      = '0;
        hex_mode   = 1'b0;
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;
        push_scan(64'h0, 64'h0, 8);
        @(negedge clk);
        check("srclr_n after reset", 32'(srclr_n_w), 32'(3'b111));

        do_load(32'h1239ABCD, 8'h00, 8'h00, 1'b1);
        scramble();
        next_scan(64'h065B4F6F777C395E, 64'h065B4F6F777C395E);

        do_load(32'h76543A10, 8'h11, 8'h10, 1'b0);
        scramble();
        next_scan(64'h077D6D004F0006BF, 64'h077D6D004F0006BF);

        do_load(32'h00000120, 8'h00, 8'h00, 1'b1);
        scramble();
        next_scan(64'h3F3F3F3F3F065B3F, 64'h0000000000065B3F);

        do_load(32'h00000120, 8'h20, 8'h00, 1'b1);
        scramble();
        next_scan(64'h3F3FBF3F3F065B3F, 64'h0000BF3F3F065B3F);

        // Back-to-back loads: the second is held until the digit-0 transfer.
        do_load(32'h00C00FE8, 8'h01, 8'h00, 1'b1);
        value      = 32'h12345678;
        dp         = 8'h00;
        blank      = 8'h80;
        hex_mode   = 1'b0;
        load_valid = 1'b1;
        check("b2b second load held off", 32'(load_ready_w), 32'(3'b000));
        wait_scan_done();
        check("ready low at scan end", 32'(load_ready_w), 32'(3'b000));
        push_scan(64'h3F3F393F3F7179FF, 64'h0000393F3F7179FF, 8);
        @(negedge clk);
        check("ready low in transfer cycle", 32'(load_ready_w), 32'(3'b000));
        @(negedge clk);
        check("ready back after transfer", 32'(load_ready_w), 32'(3'b111));
        @(negedge clk);
        load_valid = 1'b0;
        scramble();
        next_scan(64'h005B4F666D7D077F, 64'h005B4F666D7D077F);

        // Reset at slot 9 of digit 4 with an update pending: frame aborted, update dropped.
        wait_scan_done();
        c0 = cyc;
        push_scan(64'h005B4F666D7D077F, 64'h005B4F666D7D077F, 4);
        repeat (40) @(negedge clk);
        do_load(32'hDEADBEEF, 8'hFF, 8'h00, 1'b1);
        while (cyc < c0 + 325) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("mid-frame reset");
        rst = 1'b0;
        push_scan(64'h0, 64'h0, 8);
        wait_scan_done();
        @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
